bias_sched_ctrl: RTL and testbench

BIAS_SCHED_CTRL -- requirements
Module: bias_sched_ctrl

---
 rtl/bias_pkg.sv | 16 +
 rtl/bias_regfile.sv | 30 +++
 rtl/bias_sched_ctrl.sv | 152 +++++++++++++++
 tb/tb_bias_sched_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bias_pkg.sv
// Shared types and default widths for the bias scheduler.
// Saturation mode is selected by BIAS_SAT_EN (see bias_sched_ctrl).
package bias_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int N_CH       = 4;
  localparam int DEF_DATA_W = 35;
  localparam int DEF_BIAS_W = 34;
  localparam int DEF_PIX_W  = 16;

endpackage

// File: rtl/bias_regfile.sv
// Per-channel bias storage: 4 entries, synchronous write, asynchronous read.
// Entries clear on reset.
module bias_regfile
  import bias_pkg::*;
#(
  parameter int BIAS_W = DEF_BIAS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [1:0]        i_waddr,
  input  logic [BIAS_W-1:0] i_wdata,
  input  logic [1:0]        i_raddr,
  output logic [BIAS_W-1:0] o_rdata
);

  logic [BIAS_W-1:0] r_mem [N_CH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++)
        r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/bias_sched_ctrl.sv
// Frame scheduler adding a per-channel bias to a result stream.
// Define BIAS_SAT_EN for a signed saturating add instead of wrap.
module bias_sched_ctrl
  import bias_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int BIAS_W = DEF_BIAS_W,
  parameter int PIX_W  = DEF_PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [BIAS_W-1:0] cfg_data,
  input  logic              start,
  input  logic [PIX_W-1:0]  num_pix,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_ch,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [1:0]        r_ch;
  logic [PIX_W-1:0]  r_pix;
  logic [PIX_W-1:0]  r_num_pix;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_out_ch;
  logic              r_out_last;
  logic              r_busy;
  logic              r_done;

  logic [BIAS_W-1:0] w_bias;
  logic [DATA_W-1:0] w_bias_x;
  logic [DATA_W-1:0] w_raw;
  logic [DATA_W-1:0] w_sum;
  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_last_beat;
  logic              w_cfg_we;

  // Bias is frozen for the whole frame.
  assign w_cfg_we = cfg_we && (r_state != S_RUN);

  bias_regfile #(.BIAS_W(BIAS_W)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_cfg_we),
    .i_waddr (cfg_addr),
    .i_wdata (cfg_data),
    .i_raddr (r_ch),
    .o_rdata (w_bias)
  );

  // out_last blocks intake once the final beat is captured.
  assign in_ready = (r_state == S_RUN) && !r_out_last &&
                    (!r_out_valid || out_ready);
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;

  assign w_bias_x = {{(DATA_W-BIAS_W){w_bias[BIAS_W-1]}}, w_bias};
  assign w_raw    = in_data + w_bias_x;

`ifdef BIAS_SAT_EN
  logic w_ovf;
  assign w_ovf = (in_data[DATA_W-1] == w_bias_x[DATA_W-1]) &&
                 (w_raw[DATA_W-1] != in_data[DATA_W-1]);
  assign w_sum = !w_ovf ? w_raw :
                 in_data[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                     {1'b0, {(DATA_W-1){1'b1}}};
`else
  assign w_sum = w_raw;
`endif

  assign w_last_beat = (r_ch == 2'(N_CH-1)) &&
                       (r_pix == r_num_pix - PIX_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_pix       <= '0;
      r_num_pix   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sum;
        r_out_ch    <= r_ch;
        r_out_last  <= w_last_beat;
        r_ch        <= r_ch + 2'd1;
        if (r_ch == 2'(N_CH-1))
          r_pix <= r_pix + PIX_W'(1);
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_pix <= num_pix;
            r_ch      <= '0;
            r_pix     <= '0;
            r_busy    <= 1'b1;
            if (num_pix == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (w_out_hs && r_out_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_bias_sched_ctrl.sv
// Scoreboard bench for bias_sched_ctrl: directed frames, stalls,
// frozen config, overflow and mid-frame reset.
module tb_bias_sched_ctrl;

  localparam int DW = 35;
  localparam int BW = 34;
  localparam int PW = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [1:0]    ch;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = '0;
  logic [BW-1:0] cfg_data = '0;
  logic          start = 1'b0;
  logic [PW-1:0] num_pix = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [1:0]    out_ch;
  logic          out_last;
  logic          busy;
  logic          done;

  int n_pass = 0;
  int n_total = 0;
  beat_t sb[$];

  bias_sched_ctrl #(.DATA_W(DW), .BIAS_W(BW), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .num_pix(num_pix),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", {29'd0, out_data}, 64'hDEAD);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_ch", 64'(out_ch), 64'(e.ch));
        chk("out_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  task automatic cfg(input logic [1:0] a, input logic [BW-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic go(input logic [PW-1:0] n);
    start = 1'b1; num_pix = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [DW-1:0] e,
                      input logic [1:0] ch, input logic last);
    int n;
    beat_t b;
    n = 0;
    in_valid = 1'b1; in_data = d;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        chk("in_ready_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    b.data = e; b.ch = ch; b.last = last;
    sb.push_back(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("done_seen", 64'(done), 64'd1);
    @(posedge clk); #1;
    chk("done_pulse_len", 64'(done), 64'd0);
  endtask

  logic [DW-1:0] e1 [4];
  logic [DW-1:0] held;

  initial begin
    e1[0] = 35'h02566D042; e1[1] = 35'h101;
    e1[2] = 35'h0FF;       e1[3] = 35'h100;

    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Nominal frame
    cfg(2'd0, 34'h02566CF42);
    cfg(2'd1, 34'h1);
    cfg(2'd2, 34'h3FFFFFFFF);
    cfg(2'd3, 34'h0);
    go(16'd2);
    chk("busy_run", 64'(busy), 64'd1);
    for (int i = 0; i < 8; i++)
      send(35'h100, e1[i%4], 2'(i), i == 7);
    chk("done_before_hs", 64'(done), 64'd0);
    @(posedge clk); #1;
    chk("done_after_last", 64'(done), 64'd1);
    chk("busy_done", 64'(busy), 64'd1);
    @(posedge clk); #1;
    chk("done_clear", 64'(done), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);

    // Empty frame
    go(16'd0);
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_no_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("empty_done_clear", 64'(done), 64'd0);
    chk("empty_no_valid2", 64'(out_valid), 64'd0);

    // Backpressure stall
    go(16'd1);
    send(35'h100, e1[0], 2'd0, 1'b0);
    out_ready = 1'b0;
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'(held));
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++)
      send(35'h100, e1[i], 2'(i), i == 3);
    wait_done();

    // Config write during RUN is ignored; after done it applies
    go(16'd1);
    cfg(2'd1, 34'h5);
    for (int i = 0; i < 4; i++)
      send(35'h100, e1[i], 2'(i), i == 3);
    wait_done();
    cfg(2'd1, 34'h5);
    go(16'd1);
    send(35'h100, e1[0], 2'd0, 1'b0);
    send(35'h100, 35'h105, 2'd1, 1'b0);
    send(35'h100, e1[2], 2'd2, 1'b0);
    send(35'h100, e1[3], 2'd3, 1'b1);
    wait_done();

    // Positive overflow
    cfg(2'd0, 34'h1);
    go(16'd1);
`ifdef BIAS_SAT_EN
    send(35'h3FFFFFFFF, 35'h3FFFFFFFF, 2'd0, 1'b0);
`else
    send(35'h3FFFFFFFF, 35'h400000000, 2'd0, 1'b0);
`endif
    send(35'h0, 35'h5, 2'd1, 1'b0);
    send(35'h0, 35'h7FFFFFFFF, 2'd2, 1'b0);
    send(35'h0, 35'h0, 2'd3, 1'b1);
    wait_done();

    // Mid-frame reset
    go(16'd2);
    send(35'h10, 35'h11, 2'd0, 1'b0);
    send(35'h10, 35'h15, 2'd1, 1'b0);
    send(35'h10, 35'h0F, 2'd2, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_data", 64'(out_data), 64'd0);
    chk("abort_ch", 64'(out_ch), 64'd0);
    chk("abort_last", 64'(out_last), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_done", 64'(done), 64'd0);
    go(16'd1);
    for (int i = 0; i < 4; i++)
      send(35'h20 + 35'(i), 35'h20 + 35'(i), 2'(i), i == 3);
    wait_done();

    repeat (3) @(posedge clk); #1;
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
